// File: rtl/prbs_pkg.sv
// Shared definitions for the parallel PRBS generator: mode encoding,
// polynomial order/tap lookup and the active-order mask.
package prbs_pkg;

    localparam int PRBS_MAX_ORDER = 31;

    localparam logic [2:0] MODE_PRBS7  = 3'd0;
    localparam logic [2:0] MODE_PRBS9  = 3'd1;
    localparam logic [2:0] MODE_PRBS15 = 3'd2;
    localparam logic [2:0] MODE_PRBS23 = 3'd3;
    localparam logic [2:0] MODE_PRBS31 = 3'd4;

    // Encodings 5..7 fall through to PRBS31.
    function automatic logic [4:0] prbs_order(input logic [2:0] mode);
        case (mode)
            MODE_PRBS7:  return 5'd7;
            MODE_PRBS9:  return 5'd9;
            MODE_PRBS15: return 5'd15;
            MODE_PRBS23: return 5'd23;
            default:     return 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap(input logic [2:0] mode);
        case (mode)
            MODE_PRBS7:  return 5'd1;
            MODE_PRBS9:  return 5'd4;
            MODE_PRBS15: return 5'd1;
            MODE_PRBS23: return 5'd5;
            default:     return 5'd3;
        endcase
    endfunction

    function automatic logic [PRBS_MAX_ORDER-1:0] prbs_mask(input logic [4:0] order);
        logic [PRBS_MAX_ORDER:0] ones;
        ones = (32'd1 << order) - 32'd1;
        return ones[PRBS_MAX_ORDER-1:0];
    endfunction

endpackage

// File: rtl/prbs_gen_par_if.sv
// Control and data bundle between a PRBS consumer (master) and the generator (slave).
// Handshake: a word is produced when i_enable && i_valid; o_valid marks it one cycle later, no backpressure.
interface prbs_gen_par_if
    import prbs_pkg::*;
#(
    parameter int W = 4
);
    logic                      i_enable;
    logic                      i_valid;
    logic [2:0]                i_mode;
    logic                      i_load;
    logic [PRBS_MAX_ORDER-1:0] i_seed;
    logic                      i_invert;
    logic [W-1:0]              o_data;
    logic                      o_valid;
    logic                      o_lockup;
    logic [7:0]                o_lock_cnt;

    modport master (
        output i_enable, i_valid, i_mode, i_load, i_seed, i_invert,
        input  o_data, o_valid, o_lockup, o_lock_cnt
    );

    modport slave (
        input  i_enable, i_valid, i_mode, i_load, i_seed, i_invert,
        output o_data, o_valid, o_lockup, o_lock_cnt
    );
endinterface

// File: rtl/prbs_lfsr_step.sv
// One Fibonacci LFSR step: right shift, s[0] out, feedback into bit order-1.
module prbs_lfsr_step
    import prbs_pkg::*;
(
    input  logic [PRBS_MAX_ORDER-1:0] state,
    input  logic [4:0]                order,
    input  logic [4:0]                tap,
    output logic [PRBS_MAX_ORDER-1:0] next_state,
    output logic                      bit_out
);
    logic fb;

    assign fb         = state[0] ^ state[tap];
    assign bit_out    = state[0];
    // Upper bits are already zero, so the shifted-in zero at order-1 is simply OR-ed with fb.
    assign next_state = (state >> 1)
                      | ({{(PRBS_MAX_ORDER-1){1'b0}}, fb} << (order - 5'd1));
endmodule

// File: rtl/prbs_gen_par.sv
// Parallel PRBS generator: W chained LFSR steps per accepted advance, with
// seed load, mode switch reseed, polarity inversion and all-zero recovery.
module prbs_gen_par
    import prbs_pkg::*;
#(
    parameter int                        W        = 4,
    parameter logic [2:0]                MODE_RST = 3'd1,
    parameter logic [PRBS_MAX_ORDER-1:0] SEED_RST = 31'h7FFF_FFFF
) (
    input  logic           clock,
    input  logic           i_reset,
    prbs_gen_par_if.slave  bus
);
    logic [2:0]                r_mode;
    logic [PRBS_MAX_ORDER-1:0] s_q;
    logic [W-1:0]              data_q;
    logic                      valid_q;
    logic [7:0]                lock_cnt_q;

    logic [4:0]                cur_order;
    logic [4:0]                cur_tap;
    logic [PRBS_MAX_ORDER-1:0] cur_mask;
    logic [W-1:0]              step_bits;
    logic [PRBS_MAX_ORDER-1:0] s_adv;
    logic                      mode_chg;
    logic                      lock_hit;
    logic                      advance;

    assign cur_order = prbs_order(r_mode);
    assign cur_tap   = prbs_tap(r_mode);
    assign cur_mask  = prbs_mask(cur_order);

    for (genvar i = 0; i < W; i++) begin : g_step
        logic [PRBS_MAX_ORDER-1:0] cur;
        logic [PRBS_MAX_ORDER-1:0] nxt;
        if (i == 0) begin : g_first
            assign cur = s_q;
        end else begin : g_rest
            assign cur = g_step[i-1].nxt;
        end
        prbs_lfsr_step u_step (
            .state      (cur),
            .order      (cur_order),
            .tap        (cur_tap),
            .next_state (nxt),
            .bit_out    (step_bits[i])
        );
    end
    assign s_adv = g_step[W-1].nxt;

    // Priority: mode change, load, lock-up recovery, advance.
    assign mode_chg = (r_mode != bus.i_mode);
    assign lock_hit = !mode_chg && !bus.i_load && ((s_q & cur_mask) == '0);
    assign advance  = !mode_chg && !bus.i_load && !lock_hit && bus.i_enable && bus.i_valid;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_mode     <= MODE_RST;
            s_q        <= SEED_RST & prbs_mask(prbs_order(MODE_RST));
            data_q     <= '0;
            valid_q    <= 1'b0;
            lock_cnt_q <= 8'd0;
        end else begin
            valid_q <= 1'b0;
            if (mode_chg) begin
                r_mode <= bus.i_mode;
                s_q    <= SEED_RST & prbs_mask(prbs_order(bus.i_mode));
            end else if (bus.i_load) begin
                s_q <= bus.i_seed & cur_mask;
            end else if (lock_hit) begin
                s_q <= cur_mask;
                if (lock_cnt_q != 8'hFF) lock_cnt_q <= lock_cnt_q + 8'd1;
            end else if (advance) begin
                data_q  <= bus.i_invert ? ~step_bits : step_bits;
                valid_q <= 1'b1;
                s_q     <= s_adv;
            end
        end
    end

    // Lock-up flags the cycle the zero state is seen; the reseed lands on the next edge.
    assign bus.o_lockup   = lock_hit && i_reset;
    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_lock_cnt = lock_cnt_q;
endmodule
